// File: rtl/fifo_flags_if.sv
// Bus interface for fifo_flags.
// master: producer/consumer side. It drives we/din/re and observes data, flags and count.
// slave:  FIFO side. It accepts requests and drives dout, dout_valid, flags and count.
interface fifo_flags_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4
);
  logic                  we;
  logic [DATA_WIDTH-1:0] din;
  logic                  re;
  logic [DATA_WIDTH-1:0] dout;
  logic                  dout_valid;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output we, din, re,
    input  dout, dout_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );

  modport slave (
    input  we, din, re,
    output dout, dout_valid, empty, full, almost_empty, almost_full,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_flags.sv
// Parametrised synchronous FIFO with occupancy count, almost flags,
// a read-data valid strobe and sticky overflow/underflow error flags.
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fifo_flags_if.slave. Inputs are we, din and re. Outputs are dout,
//          dout_valid, empty, full, almost_empty, almost_full, count,
//          overflow and underflow.
module fifo_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_LEVEL   = (2 ** ADDR_WIDTH) - 2,
  parameter int unsigned AE_LEVEL   = 2
) (
  input logic          clk,
  input logic          rst,
  fifo_flags_if.slave  bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  empty_c;
  logic                  full_c;
  logic                  wr_ok;
  logic                  re_ok;

  // Accept logic and next count.
  // When the FIFO is full, a write is still accepted if a read frees a slot
  // in the same cycle.
  always_comb begin
    empty_c = (count_q == '0);
    full_c  = (count_q == CW'(DEPTH));
    re_ok   = bus.re && !empty_c;
    wr_ok   = bus.we && (!full_c || re_ok);
    count_d = count_q;
    case ({wr_ok, re_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers, count, read data and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr        <= '0;
      r_ptr        <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      count_q      <= count_d;
      dout_valid_q <= re_ok;
      if (wr_ok) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (re_ok) begin
        r_ptr  <= r_ptr + ADDR_WIDTH'(1);
        dout_q <= mem[r_ptr];
      end
      if (bus.we && !wr_ok) overflow_q  <= 1'b1;
      if (bus.re && !re_ok) underflow_q <= 1'b1;
    end
  end

  // Storage is not reset.
  // On a simultaneous read and write at full, both pointers address the same slot.
  // The read samples the old entry before the write lands.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) mem[w_ptr] <= bus.din;
  end

  assign bus.dout         = dout_q;
  assign bus.dout_valid   = dout_valid_q;
  assign bus.count        = count_q;
  assign bus.empty        = empty_c;
  assign bus.full         = full_c;
  assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
  assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: doc/fifo_flags.md
# fifo_flags

Parametrised synchronous FIFO, the next-generation buffer for the Morse decoder datapath, sitting between the symbol/character decoder and the display/UART consumer. It generalises the existing 8-bit, 16-deep buffer to configurable width and depth. It adds synchronous reset, defined simultaneous read/write behaviour at the full and empty boundaries, and a visible occupancy count. It also adds programmable almost-full/almost-empty flags, a read-data valid strobe, and sticky overflow/underflow error flags.

## Interface
- DATA_WIDTH, 8, width of each entry
- ADDR_WIDTH, 4, pointer width; depth DEPTH = 2**ADDR_WIDTH
- AF_LEVEL, DEPTH-2, almost_full asserted when count >= AF_LEVEL (legal range 1..DEPTH)
- AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL (legal range 0..DEPTH-1)

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write request
- din  in  DATA_WIDTH  write data
- re  in  1  read request
- dout  out  DATA_WIDTH  registered read data
- dout_valid  out  1  one-cycle strobe: dout updated this cycle
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- almost_empty  out  1  count <= AE_LEVEL
- almost_full  out  1  count >= AF_LEVEL
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: write attempted while full and not accepted
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH x DATA_WIDTH array; write pointer w_ptr and read pointer r_ptr, ADDR_WIDTH bits each, wrap modulo DEPTH naturally (DEPTH-1 -> 0).
- Write accepted (wr_ok) = we && (!full || re_ok). Read accepted (re_ok) = re && !empty.
- When full, simultaneous we && re: both accepted, count unchanged, pointers both advance. The read returns the oldest entry, and the write lands in the slot that entry frees.
- When empty, simultaneous we && re: write accepted, read rejected (no bypass), underflow set, count -> 1.
- count update: +1 on wr_ok only; -1 on re_ok only; unchanged on both or neither. A single next-count expression is used, never two competing nonblocking assignments.
- Read: on re_ok, dout <= mem[r_ptr], dout_valid <= 1. Otherwise dout holds its previous value and dout_valid <= 0.
- Errors: overflow <= 1 on we && !wr_ok; underflow <= 1 on re && !re_ok. Both hold until rst. A rejected access changes no other state.
- Flags empty, full, almost_* are combinational decodes of registered count.
- Reset (rst high at edge): w_ptr=0, r_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0. Hence empty=1, full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? 1 : 0). Memory contents are not cleared. rst overrides any we/re in the same cycle, including mid-stream, and all pending data is discarded.

## Timing
- Write-to-flag latency: 1 cycle. count and flags reflect a write in the cycle after the accepting edge.
- Read latency: dout/dout_valid valid 1 cycle after the edge where re_ok is sampled.
- Write-to-read: data written at edge N is readable with re sampled at edge N+1, and appears on dout after edge N+1.
- Sustained throughput: one write and one read per cycle at any occupancy, including full.
- No combinational path from we/re/din to any output.

## Test plan
- Parameters DATA_WIDTH=8, ADDR_WIDTH=2 (DEPTH=4), AF_LEVEL=3, AE_LEVEL=1 unless noted.
- Reset/fill: rst 1 cycle, then write 0x11,0x22,0x33,0x44 on consecutive cycles. Required: count 0->1->2->3->4; almost_empty drops at count 2; almost_full rises at 3; full at 4; overflow stays 0.
- Overflow + drain: while full, write 0x55. Required: overflow=1, count=4. Then read 4 times: dout 0x11,0x22,0x33,0x44 with dout_valid each cycle; empty=1; 0x55 never appears.
- Simultaneous at full: fill with 0xA0..0xA3, then we=re=1 with din=0xB0. Required: dout=0xA0, count stays 4, overflow=0. Subsequent reads give 0xA1,0xA2,0xA3,0xB0.
- Simultaneous at empty: after reset, we=re=1 with din=0x7E. Required: underflow=1, dout_valid=0, count=1. Next read gives dout=0x7E.
- Wrap-around: 10 cycles streaming 1 write + 1 read per cycle after priming one entry. Required: in-order data across pointer wrap, count constant 1, no error flags.
- Reset mid-operation: with count=3 and overflow=1, assert rst together with we=1. Required next cycle: count=0, empty=1, overflow=0, dout=0, dout_valid=0, and the write is dropped.
